// File: rtl/associative_memory_trainer_pkg.sv
// associative_memory_trainer_pkg: constants shared with the associative memory, trainer FSM states and a ceil-log2 helper
package associative_memory_trainer_pkg;
  localparam int HV_DIMENSION = 2000;
  localparam int CLASSES = 2;
  localparam int LABEL_WIDTH = 1;
  localparam int CNT_WIDTH = 8;
  localparam int AM_CHUNK = 250;
  localparam int NUM_CHUNKS = HV_DIMENSION / AM_CHUNK;
  typedef enum logic [1:0] {IDLE, ACCUMULATE, EMIT, CLEAR} state_e;
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/associative_memory_trainer_if.sv
// associative_memory_trainer_if: training-sample input and prototype output handshakes; slave = trainer (ValidIn/HypervectorIn/LabelIn/Finalize/ReadyIn in, ReadyOut/ValidOut/PrototypeOut/LabelOut/SampleCountOut/Saturated out), master = its peer
interface associative_memory_trainer_if import associative_memory_trainer_pkg::*; #(
  parameter int HV_DIMENSION = associative_memory_trainer_pkg::HV_DIMENSION,
  parameter int LABEL_WIDTH = associative_memory_trainer_pkg::LABEL_WIDTH,
  parameter int CNT_WIDTH = associative_memory_trainer_pkg::CNT_WIDTH
);
  logic ValidIn_SI;
  logic ReadyOut_SO;
  logic [0:HV_DIMENSION-1] HypervectorIn_DI;
  logic [LABEL_WIDTH-1:0] LabelIn_DI;
  logic Finalize_SI;
  logic ValidOut_SO;
  logic ReadyIn_SI;
  logic [0:HV_DIMENSION-1] PrototypeOut_DO;
  logic [LABEL_WIDTH-1:0] LabelOut_DO;
  logic [CNT_WIDTH-1:0] SampleCountOut_DO;
  logic Saturated_SO;
  modport slave (
    input ValidIn_SI, HypervectorIn_DI, LabelIn_DI, Finalize_SI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, PrototypeOut_DO, LabelOut_DO, SampleCountOut_DO, Saturated_SO
  );
  modport master (
    output ValidIn_SI, HypervectorIn_DI, LabelIn_DI, Finalize_SI, ReadyIn_SI,
    input ReadyOut_SO, ValidOut_SO, PrototypeOut_DO, LabelOut_DO, SampleCountOut_DO, Saturated_SO
  );
endinterface

// File: rtl/associative_memory_trainer_am_class_accumulator.sv
// am_class_accumulator: one class's saturating per-bit and sample counters with majority threshold (in: clk, rst, clear_i, en_i, last_i, chunk_i, hv_i; out: proto_o, count_o, sat_o)
module am_class_accumulator import associative_memory_trainer_pkg::*; #(
  parameter int HV_DIMENSION = 8,
  parameter int AM_CHUNK = 4,
  parameter int CNT_WIDTH = 3,
  parameter int CHUNK_WIDTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  input  logic last_i,
  input  logic [CHUNK_WIDTH-1:0] chunk_i,
  input  logic [0:HV_DIMENSION-1] hv_i,
  output logic [0:HV_DIMENSION-1] proto_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic sat_o
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  logic [CNT_WIDTH-1:0] cnt_q [HV_DIMENSION];
  logic [CNT_WIDTH-1:0] cnt_d [HV_DIMENSION];
  logic [CNT_WIDTH-1:0] samp_q, samp_d;
  always_comb begin
    cnt_d = cnt_q;
    samp_d = clear_i ? '0 : samp_q;
    sat_o = 1'b0;
    proto_o = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      if (clear_i) cnt_d[i] = '0;
      else if (en_i && hv_i[i] && (i / AM_CHUNK) == int'(chunk_i)) begin
        sat_o = sat_o | (cnt_q[i] == MAX);
        cnt_d[i] = (cnt_q[i] == MAX) ? MAX : cnt_q[i] + 1'b1;
      end
      proto_o[i] = {cnt_q[i], 1'b0} > {1'b0, samp_q};
    end
    if (en_i && last_i && !clear_i) begin
      sat_o = sat_o | (samp_q == MAX);
      samp_d = (samp_q == MAX) ? MAX : samp_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      samp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      samp_q <= samp_d;
    end
  end
  assign count_o = samp_q;
endmodule

// File: rtl/associative_memory_trainer.sv
// associative_memory_trainer: accumulates labelled hypervectors per class and streams majority prototypes on finalize (Clk_CI, Reset_RI, bus: slave modport of associative_memory_trainer_if)
module associative_memory_trainer import associative_memory_trainer_pkg::*; #(
  parameter int HV_DIMENSION = associative_memory_trainer_pkg::HV_DIMENSION,
  parameter int CLASSES = associative_memory_trainer_pkg::CLASSES,
  parameter int LABEL_WIDTH = associative_memory_trainer_pkg::LABEL_WIDTH,
  parameter int CNT_WIDTH = associative_memory_trainer_pkg::CNT_WIDTH,
  parameter int AM_CHUNK = associative_memory_trainer_pkg::AM_CHUNK
) (
  input logic Clk_CI,
  input logic Reset_RI,
  associative_memory_trainer_if.slave bus
);
  localparam int NUM_CHUNKS = HV_DIMENSION / AM_CHUNK;
  localparam int CHUNK_WIDTH = ceil_log2(NUM_CHUNKS) > 0 ? ceil_log2(NUM_CHUNKS) : 1;
  localparam int SLOTS = 2 ** LABEL_WIDTH;
  state_e state_q, state_d;
  logic [CHUNK_WIDTH-1:0] chunk_q, chunk_d;
  logic [0:HV_DIMENSION-1] hv_q, hv_d, proto_q, proto_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d, label_out_q, label_out_d, nxt;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic ready_q, ready_d, valid_q, valid_d, sat_q, sat_d, last;
  logic [0:HV_DIMENSION-1] proto_w [SLOTS];
  logic [CNT_WIDTH-1:0] count_w [SLOTS];
  logic [SLOTS-1:0] sat_w;
  assign last = chunk_q == CHUNK_WIDTH'(NUM_CHUNKS - 1);
  for (genvar k = 0; k < SLOTS; k++) begin : g_cls
    if (k < CLASSES) begin : g_acc
      am_class_accumulator #(
        .HV_DIMENSION(HV_DIMENSION), .AM_CHUNK(AM_CHUNK), .CNT_WIDTH(CNT_WIDTH), .CHUNK_WIDTH(CHUNK_WIDTH)
      ) u_acc (
        .clk(Clk_CI), .rst(Reset_RI), .clear_i(state_q == CLEAR),
        .en_i(state_q == ACCUMULATE && label_q == LABEL_WIDTH'(k)), .last_i(last),
        .chunk_i(chunk_q), .hv_i(hv_q), .proto_o(proto_w[k]), .count_o(count_w[k]), .sat_o(sat_w[k])
      );
    end else begin : g_nil
      assign proto_w[k] = '0;
      assign count_w[k] = '0;
      assign sat_w[k] = 1'b0;
    end
  end
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    hv_d = hv_q;
    label_d = label_q;
    valid_d = valid_q;
    proto_d = proto_q;
    label_out_d = label_out_q;
    count_d = count_q;
    nxt = label_out_q + 1'b1;
    sat_d = (state_q == CLEAR) ? 1'b0 : sat_q | (|sat_w);
    case (state_q)
      IDLE: begin
        if (bus.ValidIn_SI) begin
          hv_d = bus.HypervectorIn_DI;
          label_d = bus.LabelIn_DI;
          chunk_d = '0;
          state_d = (int'(bus.LabelIn_DI) < CLASSES) ? ACCUMULATE : IDLE;
        end else if (bus.Finalize_SI) begin
          state_d = EMIT;
          valid_d = 1'b1;
          proto_d = proto_w[0];
          count_d = count_w[0];
          label_out_d = '0;
        end
      end
      ACCUMULATE: begin
        chunk_d = last ? '0 : chunk_q + 1'b1;
        state_d = last ? IDLE : ACCUMULATE;
      end
      EMIT: begin
        if (bus.ReadyIn_SI && int'(label_out_q) < CLASSES - 1) begin
          label_out_d = nxt;
          proto_d = proto_w[nxt];
          count_d = count_w[nxt];
        end else if (bus.ReadyIn_SI) begin
          state_d = CLEAR;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      chunk_q <= '0;
      hv_q <= '0;
      label_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      proto_q <= '0;
      label_out_q <= '0;
      count_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      hv_q <= hv_d;
      label_q <= label_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      proto_q <= proto_d;
      label_out_q <= label_out_d;
      count_q <= count_d;
      sat_q <= sat_d;
    end
  end
  assign bus.ReadyOut_SO = ready_q;
  assign bus.ValidOut_SO = valid_q;
  assign bus.PrototypeOut_DO = proto_q;
  assign bus.LabelOut_DO = label_out_q;
  assign bus.SampleCountOut_DO = count_q;
  assign bus.Saturated_SO = sat_q;
endmodule

// File: doc/associative_memory_trainer.md
Name: associative_memory_trainer

Overview:
Builds the class prototype hypervectors that the associative memory later compares queries against. It accepts labelled training hypervectors over a valid/ready handshake and keeps saturating per-bit counters for each class. On a finalize request it thresholds every counter by majority and streams out one prototype per class over a second valid/ready handshake. It sits after the modality encoders and the majority fusion stage, on the training path.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits, MSB-first indexing [0:HV_DIMENSION-1]
CLASSES, 2, number of classes
LABEL_WIDTH, 1, label width; must satisfy 2^LABEL_WIDTH >= CLASSES
CNT_WIDTH, 8, width of each per-bit counter and each per-class sample counter
AM_CHUNK, 250, bits updated per cycle; HV_DIMENSION must be divisible by AM_CHUNK; NUM_CHUNKS = HV_DIMENSION/AM_CHUNK

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  synchronous, active-high reset
ValidIn_SI  in  1  training sample valid
ReadyOut_SO  out  1  trainer can accept a sample or a finalize request
HypervectorIn_DI  in  HV_DIMENSION  training hypervector
LabelIn_DI  in  LABEL_WIDTH  class of the training hypervector
Finalize_SI  in  1  level request to emit the prototypes, then clear the counters
ValidOut_SO  out  1  prototype beat valid
ReadyIn_SI  in  1  downstream accepts the prototype beat
PrototypeOut_DO  out  HV_DIMENSION  thresholded prototype
LabelOut_DO  out  LABEL_WIDTH  class index of the current beat
SampleCountOut_DO  out  CNT_WIDTH  number of samples accumulated for that class
Saturated_SO  out  1  sticky flag: some counter has saturated since the last clear

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - all counters 0; state IDLE
  - ReadyOut_SO = 1, ValidOut_SO = 0
  - PrototypeOut_DO, LabelOut_DO and SampleCountOut_DO = 0; Saturated_SO = 0
  - reset in any state aborts the operation in progress with no partial output.
- States: IDLE, ACCUMULATE, EMIT, CLEAR.
- IDLE:
  - ReadyOut_SO = 1.
  - ValidIn_SI=1 with label < CLASSES: latch the hypervector and label, go to ACCUMULATE with chunk counter 0.
  - ValidIn_SI=1 with label >= CLASSES: sample is consumed and discarded; stay in IDLE.
  - Finalize_SI=1 with ValidIn_SI=0: load output registers for class 0 and go to EMIT.
  - ValidIn_SI and Finalize_SI both high: the sample wins. Finalize_SI must be held by the requester until it is taken.
- ACCUMULATE:
  - Lasts exactly NUM_CHUNKS cycles with ReadyOut_SO = 0.
  - On chunk c, each bit i in [c*AM_CHUNK, (c+1)*AM_CHUNK) adds the latched bit to counter[label][i].
  - Counters saturate at 2^CNT_WIDTH-1; a saturation event sets Saturated_SO.
  - On the last chunk, sample count[label] increments (also saturating, also sets Saturated_SO), then the block returns to IDLE.
  - Sample-to-ready latency is NUM_CHUNKS+1 cycles.
- EMIT:
  - ValidOut_SO = 1 and ReadyOut_SO = 0.
  - Prototype bit i = 1 iff 2*counter[k][i] > count[k], compared at CNT_WIDTH+1 bits. Ties give 0.
  - A class with zero samples gives an all-zero prototype and a count of 0.
  - All outputs are registered and stay stable while ReadyIn_SI = 0.
  - On a handshake with k < CLASSES-1: load class k+1 on the same edge.
  - On a handshake with k = CLASSES-1: go to CLEAR.
- CLEAR: one cycle; zero all counters, sample counts and Saturated_SO; drop ValidOut_SO; go to IDLE.
- Saturated_SO holds its value through EMIT.

Decomposition:
- Shared constants header holds HV_DIMENSION, CLASSES, LABEL_WIDTH, AM_CHUNK and derived NUM_CHUNKS/ceilLog2; these are shared with the associative memory.
- One sub-module, am_class_accumulator: one class's counter array with a chunk-select saturating increment, its sample counter, and combinational majority threshold. It is instantiated CLASSES times.
- Top level holds the FSM, chunk counter, input latches and output registers.

Test Plan:
(All with HV_DIMENSION=8, AM_CHUNK=4, CLASSES=2, CNT_WIDTH=3.)
- Class 0 samples 8'b11110000, 8'b11001100, 8'b10101010, then finalize -> beat 0: prototype 8'b11101000, count 3; beat 1: 8'h00, count 0.
- Class 1 samples 8'hFF, 8'h00 (tie), then finalize -> beat 1 prototype 8'h00, count 2.
- Sample accepted at edge t -> ReadyOut_SO low in cycles t+1 and t+2, high at t+3. Sample and finalize asserted together -> sample taken first, finalize taken next IDLE cycle.
- ReadyIn_SI held low 5 cycles in EMIT -> ValidOut_SO and PrototypeOut_DO stable. After both beats, CLEAR takes 1 cycle. A second finalize -> both prototypes 0 with count 0.
- Eight class-0 samples of 8'hFF -> Saturated_SO=1, count 7, prototype 8'hFF. Flag clears after CLEAR.
- Label 1 sample followed by reset asserted during ACCUMULATE, then finalize -> all-zero outputs, count 0. A sample whose label is out of range (widen LABEL_WIDTH to 2, use label 3) is consumed with no effect.
